// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and requester indices for the result bus.
package cpu_pkg;

   localparam int ROB_W  = 3;
   localparam int DATA_W = 32;

   localparam int REQ_ADD  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_BNE  = 2;

   typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr wins.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= N) s = s - N;
      return IW'(s);
   endfunction

   // Scan from the farthest offset back to ptr so the nearest hit is the one left standing.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int off = N - 1; off >= 0; off--) begin
         if (req[wrap(ptr, off)]) begin
            grant              = '0;
            grant[wrap(ptr, off)] = 1'b1;
            idx                = wrap(ptr, off);
            any                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per producer, round-robin
// broadcast of one buffered result per cycle, flush discards in-flight results.
module cdb_arbiter import cpu_pkg::*; #(
   parameter int NUM_REQ = 3,
   parameter int ROB_W   = cpu_pkg::ROB_W,
   parameter int DATA_W  = cpu_pkg::DATA_W,
   parameter int CNT_W   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      iscast_out,
   output logic [ROB_W-1:0]          robNum_out,
   output logic [DATA_W-1:0]         data_out,
   output logic [1:0]                grant_id,
   output logic [CNT_W-1:0]          contention_count
);

   logic [NUM_REQ-1:0] buf_full;
   logic [ROB_W-1:0]   buf_rob  [NUM_REQ];
   logic [DATA_W-1:0]  buf_data [NUM_REQ];
   req_idx_t           rr_ptr;

   logic [NUM_REQ-1:0] grant;
   req_idx_t           win_idx;
   logic               win_any;
   req_idx_t           next_ptr;
   logic               contended;

   rr_pick #(.N(NUM_REQ), .IW(2)) u_pick (
      .req   (buf_full),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // A buffer can take a new result if empty or draining this cycle; never during flush/reset.
   always_comb begin
      req_ready = (~buf_full | grant) & {NUM_REQ{~flush & ~reset}};
      next_ptr  = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 2'd1;
      contended = ($countones(buf_full) >= 2);
   end

   // Buffers, broadcast registers, pointer and contention counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         buf_full         <= '0;
         rr_ptr           <= '0;
         iscast_out       <= 1'b0;
         robNum_out       <= '0;
         data_out         <= '0;
         grant_id         <= '0;
         contention_count <= '0;
      end else if (flush) begin
         buf_full   <= '0;
         iscast_out <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               buf_full[i] <= 1'b1;
               buf_rob[i]  <= req_rob[i*ROB_W +: ROB_W];
               buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               buf_full[i] <= 1'b0;
            end
         end
         if (win_any) begin
            iscast_out <= 1'b1;
            robNum_out <= buf_rob[win_idx];
            data_out   <= buf_data[win_idx];
            grant_id   <= win_idx;
            rr_ptr     <= next_ptr;
         end else begin
            iscast_out <= 1'b0;
         end
         if (contended && (contention_count != '1))
            contention_count <= contention_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-free behavioural model.
module tb_cdb_arbiter;

   logic        clock = 1'b0;
   logic        reset, flush;
   logic [2:0]  req_valid;
   logic [8:0]  req_rob;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        iscast_out;
   logic [2:0]  robNum_out;
   logic [31:0] data_out;
   logic [1:0]  grant_id;
   logic [15:0] contention_count;

   cdb_arbiter dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_rob(req_rob), .req_data(req_data),
      .req_ready(req_ready), .iscast_out(iscast_out), .robNum_out(robNum_out),
      .data_out(data_out), .grant_id(grant_id), .contention_count(contention_count)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int errs    = 0;

   // reference model state
   logic        m_full [3];
   logic [2:0]  m_rob  [3];
   logic [31:0] m_data [3];
   int          m_ptr;
   logic        m_cast;
   logic [2:0]  m_robout;
   logic [31:0] m_dataout;
   int          m_gid;
   int          m_cnt;
   logic [2:0]  exp_ready;
   int          gcount [3];

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int winner();
      for (int k = 0; k < 3; k++) begin
         if (m_full[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
      end
      return -1;
   endfunction

   // One clock: drive at negedge, check ready, update model at posedge, check outputs.
   task automatic cycle(input logic rs, input logic fl, input logic [2:0] v,
                        input logic [8:0] rb, input logic [95:0] dt);
      int w, nfull;
      reset = rs; flush = fl; req_valid = v; req_rob = rb; req_data = dt;
      #1;
      w = winner();
      for (int i = 0; i < 3; i++)
         exp_ready[i] = (!rs && !fl) && (!m_full[i] || i == w);
      chk_eq("ready", req_ready, exp_ready);
      @(posedge clock);
      if (rs) begin
         for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
         m_ptr = 0; m_cast = 0; m_robout = 0; m_dataout = 0; m_gid = 0; m_cnt = 0;
      end else if (fl) begin
         for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
         m_cast = 0;
      end else begin
         nfull = 0;
         for (int i = 0; i < 3; i++) nfull += int'(m_full[i]);
         if (nfull >= 2 && m_cnt < 65535) m_cnt++;
         if (w >= 0) begin
            m_cast = 1; m_robout = m_rob[w]; m_dataout = m_data[w]; m_gid = w;
            m_ptr = (w + 1) % 3; m_full[w] = 1'b0;
         end else begin
            m_cast = 0;
         end
         for (int i = 0; i < 3; i++) begin
            if (v[i] && exp_ready[i]) begin
               m_full[i] = 1'b1; m_rob[i] = rb[i*3 +: 3]; m_data[i] = dt[i*32 +: 32];
            end
         end
      end
      @(negedge clock);
      chk_eq("iscast", iscast_out, m_cast);
      chk_eq("robNum", robNum_out, m_robout);
      chk_eq("data", data_out, m_dataout);
      chk_eq("contention", contention_count, m_cnt[15:0]);
      if (m_cast) begin
         chk_eq("grant_id", grant_id, m_gid[1:0]);
         gcount[grant_id]++;
      end
   endtask

   task automatic rand_cycle(input int vprob, input int fprob);
      logic [2:0] v;
      for (int i = 0; i < 3; i++) v[i] = ($urandom_range(99) < vprob);
      cycle(1'b0, ($urandom_range(99) < fprob), v, 9'($urandom),
            {$urandom, $urandom, $urandom});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_full[i] = 0; m_rob[i] = 0; m_data[i] = 0; gcount[i] = 0;
      end
      m_ptr = 0; m_cast = 0; m_robout = 0; m_dataout = 0; m_gid = 0; m_cnt = 0;
      reset = 1; flush = 0; req_valid = 0; req_rob = 0; req_data = 0;
      @(negedge clock);

      // single request
      cycle(1, 0, 3'b000, 9'd0, 96'd0);
      cycle(0, 0, 3'b001, 9'd5, {64'd0, 32'h1234});
      cycle(0, 0, 3'b000, 9'd0, 96'd0);
      chk_eq("tp1_rob", robNum_out, 3'd5);
      chk_eq("tp1_data", data_out, 32'h1234);
      cycle(0, 0, 3'b000, 9'd0, 96'd0);
      chk_eq("tp1_idle", iscast_out, 1'b0);

      // simultaneous burst, rob 1,2,3
      cycle(1, 0, 3'b000, 9'd0, 96'd0);
      cycle(0, 0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'd30, 32'd20, 32'd10});
      for (int k = 0; k < 4; k++) cycle(0, 0, 3'b000, 9'd0, 96'd0);
      chk_eq("burst_cnt", contention_count, 16'd2);

      // streaming fairness
      for (int i = 0; i < 3; i++) gcount[i] = 0;
      for (int k = 0; k < 30; k++)
         cycle(0, 0, 3'b111, 9'($urandom), {$urandom, $urandom, $urandom});
      for (int i = 0; i < 3; i++)
         chk_eq("fair", (gcount[i] >= 9 && gcount[i] <= 11), 1'b1);

      // back-to-back single load source
      for (int k = 0; k < 6; k++) cycle(0, 0, 3'b000, 9'd0, 96'd0);
      for (int k = 0; k < 10; k++)
         cycle(0, 0, 3'b010, 9'(k % 8) << 3, {32'd0, 32'(k), 32'd0});

      // flush mid-burst with a request dropped in the flush cycle
      cycle(0, 0, 3'b000, 9'd0, 96'd0);
      cycle(0, 0, 3'b000, 9'd0, 96'd0);
      cycle(0, 0, 3'b101, {3'd6, 3'd0, 3'd4}, {32'd6, 32'd0, 32'd4});
      cycle(0, 1, 3'b111, {3'd7, 3'd7, 3'd7}, {32'd7, 32'd7, 32'd7});
      for (int k = 0; k < 3; k++) cycle(0, 0, 3'b000, 9'd0, 96'd0);
      cycle(0, 0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'd3, 32'd2, 32'd1});
      cycle(0, 0, 3'b000, 9'd0, 96'd0);

      // reset overriding flush and traffic
      cycle(1, 1, 3'b111, 9'h1ff, {96{1'b1}});
      chk_eq("rst_cnt", contention_count, 16'd0);
      cycle(0, 0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'd3, 32'd2, 32'd1});
      cycle(0, 0, 3'b000, 9'd0, 96'd0);
      chk_eq("rst_first", grant_id, 2'd0);

      // random phases with varying load and occasional flush/reset
      for (int ph = 0; ph < 8; ph++) begin
         int vp;
         vp = (ph * 15) % 100 + 5;
         for (int k = 0; k < 250; k++) begin
            if ($urandom_range(199) == 0)
               cycle(1, $urandom_range(1), 3'($urandom), 9'($urandom), {$urandom, $urandom, $urandom});
            else
               rand_cycle(vp, 4);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
